// File: rtl/hack_alu_pkg.sv
// Shared constants for the pipelined Hack ALU: ctrl bit positions, named
// control codes and the pipeline depth.
package hack_alu_pkg;
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] OP_ZERO = 6'b101010;
    localparam logic [5:0] OP_ONE  = 6'b111111;
    localparam logic [5:0] OP_NEG1 = 6'b111010;
    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b010101;

    localparam int STAGES = 2;
endpackage

// File: rtl/hack_alu_preset.sv
// Operand preset for the Hack ALU: optional zeroing followed by optional
// bitwise inversion. Purely combinational.
module hack_alu_preset #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic             z,
    input  logic             n,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] zeroed;

    assign zeroed = z ? '0 : in;
    assign out    = n ? ~zeroed : zeroed;
endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides.
// Define HACK_ALU_PIPE_FLAGS_EN to compute the carry (co) and overflow (ov) flags.
import hack_alu_pkg::*;

module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);
    typedef struct packed {
        logic [WIDTH-1:0] xp;
        logic [WIDTH-1:0] yp;
        logic             f;
        logic             no;
    } s1_t;

    s1_t              s1_q;
    logic [STAGES:1]  vld_pipe;
    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] yp;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;
`ifdef HACK_ALU_PIPE_FLAGS_EN
    logic [WIDTH:0]   sum;
`else
    logic [WIDTH-1:0] sum;
`endif

    hack_alu_preset #(.WIDTH(WIDTH)) u_preset_x (
        .in(x), .z(ctrl[CTRL_ZX]), .n(ctrl[CTRL_NX]), .out(xp)
    );
    hack_alu_preset #(.WIDTH(WIDTH)) u_preset_y (
        .in(y), .z(ctrl[CTRL_ZY]), .n(ctrl[CTRL_NY]), .out(yp)
    );

    // in_ready looks through to out_ready so a full pipe still streams 1 op/cycle.
    assign s2_load   = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || s2_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[2];

`ifdef HACK_ALU_PIPE_FLAGS_EN
    assign sum = {1'b0, s1_q.xp} + {1'b0, s1_q.yp};
`else
    assign sum = s1_q.xp + s1_q.yp;
`endif
    assign r   = s1_q.f ? sum[WIDTH-1:0] : (s1_q.xp & s1_q.yp);
    assign res = s1_q.no ? ~r : r;

    // Data registers only move on real transfers, so idle cycles keep the
    // reset/last-result values rather than computing on stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            out      <= '0;
            zr       <= 1'b0;
            ng       <= 1'b0;
        end else begin
            vld_pipe[1] <= accept || (vld_pipe[1] && !s2_load);
            if (s2_load)
                vld_pipe[2] <= vld_pipe[1];
            if (accept)
                s1_q <= {xp, yp, ctrl[CTRL_F], ctrl[CTRL_NO]};
            if (s2_load && vld_pipe[1]) begin
                out <= res;
                zr  <= (res == '0);
                ng  <= res[WIDTH-1];
            end
        end
    end

`ifdef HACK_ALU_PIPE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            co <= 1'b0;
            ov <= 1'b0;
        end else if (s2_load && vld_pipe[1]) begin
            co <= s1_q.f & sum[WIDTH];
            ov <= s1_q.f & (s1_q.xp[WIDTH-1] == s1_q.yp[WIDTH-1])
                         & (sum[WIDTH-1] != s1_q.xp[WIDTH-1]);
        end
    end
`else
    assign co = 1'b0;
    assign ov = 1'b0;
`endif
endmodule
